// File: rtl/core_pipe_exec_mdu_issue_if.sv
// core_pipe_exec_mdu_issue_if: decode, multiply/divide unit and writeback signals of the MDU issue stage
interface core_pipe_exec_mdu_issue_if #(
    parameter int XLEN = 64
);
    logic            pipe_flush;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_funct3;
    logic            in_word;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic [4:0]      in_rd_addr;
    logic            mdu_valid;
    logic            mdu_op_word;
    logic            mdu_op_mul;
    logic            mdu_op_mulh;
    logic            mdu_op_mulhu;
    logic            mdu_op_mulhsu;
    logic            mdu_op_div;
    logic            mdu_op_divu;
    logic            mdu_op_rem;
    logic            mdu_op_remu;
    logic [XLEN-1:0] mdu_rs1;
    logic [XLEN-1:0] mdu_rs2;
    logic            mdu_flush;
    logic            mdu_ready;
    logic [XLEN-1:0] mdu_rd;
    logic            out_valid;
    logic            out_ready;
    logic [4:0]      out_rd_addr;
    logic [XLEN-1:0] out_data;

    modport master (
        input  pipe_flush, in_valid, in_funct3, in_word, in_rs1, in_rs2, in_rd_addr,
        input  mdu_ready, mdu_rd, out_ready,
        output in_ready, mdu_valid, mdu_op_word, mdu_op_mul, mdu_op_mulh, mdu_op_mulhu,
        output mdu_op_mulhsu, mdu_op_div, mdu_op_divu, mdu_op_rem, mdu_op_remu,
        output mdu_rs1, mdu_rs2, mdu_flush, out_valid, out_rd_addr, out_data
    );

    modport slave (
        output pipe_flush, in_valid, in_funct3, in_word, in_rs1, in_rs2, in_rd_addr,
        output mdu_ready, mdu_rd, out_ready,
        input  in_ready, mdu_valid, mdu_op_word, mdu_op_mul, mdu_op_mulh, mdu_op_mulhu,
        input  mdu_op_mulhsu, mdu_op_div, mdu_op_divu, mdu_op_rem, mdu_op_remu,
        input  mdu_rs1, mdu_rs2, mdu_flush, out_valid, out_rd_addr, out_data
    );
endinterface

// File: rtl/core_pipe_exec_mdu_issue.sv
// core_pipe_exec_mdu_issue: MDU issue/result-capture stage; CORE_MDU_ISSUE_RESCACHE_EN adds a one-entry result cache
module core_pipe_exec_mdu_issue #(
    parameter int XLEN = 64
) (
    input logic                         g_clk,
    input logic                         g_reset,
    core_pipe_exec_mdu_issue_if.master  bus
);
    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [2:0]      funct3_q;
    logic            word_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] data_q;
    logic            take;
    logic            accept;
    logic            illegal;
    logic            hit;
    logic [XLEN-1:0] hit_data;
    logic            done;
    logic            run;

    assign take    = !bus.pipe_flush && (state == IDLE || (state == RESP && bus.out_ready));
    assign accept  = take && bus.in_valid;
    assign illegal = bus.in_word && !bus.in_funct3[2] && bus.in_funct3[1:0] != 2'b00;
    assign run     = state == RUN;
    assign done    = run && bus.mdu_ready && !bus.pipe_flush;

`ifdef CORE_MDU_ISSUE_RESCACHE_EN
    logic            c_valid;
    logic [2:0]      c_funct3;
    logic            c_word;
    logic [XLEN-1:0] c_rs1;
    logic [XLEN-1:0] c_rs2;
    logic [XLEN-1:0] c_data;

    assign hit = !illegal && c_valid && c_funct3 == bus.in_funct3 && c_word == bus.in_word &&
                 c_rs1 == bus.in_rs1 && c_rs2 == bus.in_rs2;
    assign hit_data = c_data;

    // Remember the last completed op and its result; any flush forgets it
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            c_valid  <= 1'b0;
            c_funct3 <= '0;
            c_word   <= 1'b0;
            c_rs1    <= '0;
            c_rs2    <= '0;
            c_data   <= '0;
        end else if (bus.pipe_flush) begin
            c_valid <= 1'b0;
        end else if (done) begin
            c_valid  <= 1'b1;
            c_funct3 <= funct3_q;
            c_word   <= word_q;
            c_rs1    <= rs1_q;
            c_rs2    <= rs2_q;
            c_data   <= bus.mdu_rd;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    // State register
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next state: flush wins, then a new op, then unit completion, then writeback drain
    always_comb begin
        state_nxt = state;
        if (bus.pipe_flush)                    state_nxt = IDLE;
        else if (accept)                       state_nxt = (illegal || hit) ? RESP : RUN;
        else if (run && bus.mdu_ready)         state_nxt = RESP;
        else if (state == RESP && bus.out_ready) state_nxt = IDLE;
    end

    // Outputs: strobes come from registered funct3 and only during RUN
    always_comb begin
        bus.in_ready      = take;
        bus.mdu_valid     = run;
        bus.mdu_op_word   = run && word_q;
        bus.mdu_op_mul    = run && funct3_q == 3'd0;
        bus.mdu_op_mulh   = run && funct3_q == 3'd1;
        bus.mdu_op_mulhsu = run && funct3_q == 3'd2;
        bus.mdu_op_mulhu  = run && funct3_q == 3'd3;
        bus.mdu_op_div    = run && funct3_q == 3'd4;
        bus.mdu_op_divu   = run && funct3_q == 3'd5;
        bus.mdu_op_rem    = run && funct3_q == 3'd6;
        bus.mdu_op_remu   = run && funct3_q == 3'd7;
        bus.mdu_rs1       = rs1_q;
        bus.mdu_rs2       = rs2_q;
        bus.mdu_flush     = bus.pipe_flush || (run && bus.mdu_ready);
        bus.out_valid     = state == RESP;
        bus.out_rd_addr   = rd_q;
        bus.out_data      = data_q;
    end

    // Operand capture on accept; result capture from the unit, the cache, or zero for illegal ops
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            funct3_q <= '0;
            word_q   <= 1'b0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            data_q   <= '0;
        end else begin
            if (accept) begin
                funct3_q <= bus.in_funct3;
                word_q   <= bus.in_word;
                rs1_q    <= bus.in_rs1;
                rs2_q    <= bus.in_rs2;
                rd_q     <= bus.in_rd_addr;
            end
            if (accept && illegal)  data_q <= '0;
            else if (accept && hit) data_q <= hit_data;
            else if (done)          data_q <= bus.mdu_rd;
        end
    end
endmodule

// File: tb/tb_core_pipe_exec_mdu_issue.sv
// tb_core_pipe_exec_mdu_issue: directed plus randomized checks of the MDU issue stage against an M-extension model
module tb_core_pipe_exec_mdu_issue;
    logic g_clk = 1'b0;
    logic g_reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 g_clk = ~g_clk;

    core_pipe_exec_mdu_issue_if #(.XLEN(64)) bus();
    core_pipe_exec_mdu_issue #(.XLEN(64)) dut (.g_clk(g_clk), .g_reset(g_reset), .bus(bus));

    logic [7:0] strb;
    assign strb = {bus.mdu_op_remu, bus.mdu_op_rem, bus.mdu_op_divu, bus.mdu_op_div,
                   bus.mdu_op_mulhu, bus.mdu_op_mulhsu, bus.mdu_op_mulh, bus.mdu_op_mul};

    bit          c_valid = 0;
    logic [2:0]  c_f3;
    bit          c_w;
    logic [63:0] c_a, c_b, c_r;
    logic [63:0] last_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] mext(input logic [2:0] f, input logic w, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] ea, eb, p;
        logic [63:0]  r;
        logic [31:0]  r32;
        longint       sa, sb;
        int           wa, wb;
        r = '0;
        r32 = '0;
        if (w) begin
            wa = a[31:0];
            wb = b[31:0];
            case (f)
                3'd0: r32 = a[31:0] * b[31:0];
                3'd4: if (wb == 0) r32 = '1; else if (wa == int'(32'h80000000) && wb == -1) r32 = wa; else r32 = wa / wb;
                3'd5: if (b[31:0] == 0) r32 = '1; else r32 = a[31:0] / b[31:0];
                3'd6: if (wb == 0) r32 = wa; else if (wa == int'(32'h80000000) && wb == -1) r32 = 0; else r32 = wa % wb;
                3'd7: if (b[31:0] == 0) r32 = a[31:0]; else r32 = a[31:0] % b[31:0];
                default: r32 = '0;
            endcase
            r = {{32{r32[31]}}, r32};
        end else begin
            sa = a;
            sb = b;
            ea = (f != 3'd3) ? {{64{a[63]}}, a} : {64'b0, a};
            eb = (f == 3'd1) ? {{64{b[63]}}, b} : {64'b0, b};
            p = ea * eb;
            case (f)
                3'd0: r = a * b;
                3'd1, 3'd2, 3'd3: r = p[127:64];
                3'd4: if (sb == 0) r = '1; else if (sa == longint'(64'h8000000000000000) && sb == -1) r = a; else r = sa / sb;
                3'd5: if (b == 0) r = '1; else r = a / b;
                3'd6: if (sb == 0) r = a; else if (sa == longint'(64'h8000000000000000) && sb == -1) r = 0; else r = sa % sb;
                default: if (b == 0) r = a; else r = a % b;
            endcase
        end
        return r;
    endfunction

    function automatic logic [2:0] strb_f3(input logic [7:0] s);
        for (int i = 0; i < 8; i++) if (s[i]) return 3'(i);
        return 3'd0;
    endfunction

    function automatic logic [63:0] rnd64();
        case ($urandom % 7)
            0: return 64'd0;
            1: return 64'h8000000000000000;
            2: return '1;
            3: return 64'($urandom_range(0, 20));
            4: return 64'h0000000080000000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic step();
        @(posedge g_clk);
        @(negedge g_clk);
    endtask

    always @(negedge g_clk) if (!g_reset) check("excl_valid", 64'(bus.mdu_valid & bus.out_valid), 64'd0);

    task automatic accept_op(input logic [2:0] f, input logic w, input logic [63:0] a, input logic [63:0] b,
                             input logic [4:0] rd, input bit in_resp);
        bus.in_funct3 = f;
        bus.in_word = w;
        bus.in_rs1 = a;
        bus.in_rs2 = b;
        bus.in_rd_addr = rd;
        bus.in_valid = 1'b1;
        bus.out_ready = in_resp;
        #1;
        check("in_ready", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_rs1 = {$urandom, $urandom};
        bus.in_rs2 = {$urandom, $urandom};
        bus.in_funct3 = 3'($urandom);
        bus.in_rd_addr = 5'($urandom);
    endtask

    task automatic complete(input logic [2:0] f, input logic w, input logic [63:0] a, input logic [63:0] b,
                            input logic [4:0] rd, input int lat, input logic [63:0] exp);
        bit ill, hit;
        ill = w && f != 3'd0 && f < 3'd4;
`ifdef CORE_MDU_ISSUE_RESCACHE_EN
        hit = !ill && c_valid && c_f3 == f && c_w == w && c_a == a && c_b == b;
        if (hit) exp = c_r;
`else
        hit = 0;
`endif
        #1;
        if (ill || hit) begin
            check("fast_mdu_valid", bus.mdu_valid, 0);
            check("fast_out_valid", bus.out_valid, 1);
            check("fast_data", bus.out_data, ill ? 64'd0 : exp);
            last_data = ill ? 64'd0 : exp;
        end else begin
            for (int k = 1; k <= lat; k++) begin
                check("run_valid", bus.mdu_valid, 1);
                check("strobe", strb, 64'(8'd1 << f));
                check("op_word", bus.mdu_op_word, w);
                check("rs1", bus.mdu_rs1, a);
                check("rs2", bus.mdu_rs2, b);
                check("run_out_low", bus.out_valid, 0);
                if (k < lat) begin
                    check("no_flush", bus.mdu_flush, 0);
                    step();
                    #1;
                end
            end
            bus.mdu_ready = 1'b1;
            bus.mdu_rd = mext(strb_f3(strb), bus.mdu_op_word, bus.mdu_rs1, bus.mdu_rs2);
            #1;
            check("flush_done", bus.mdu_flush, 1);
            step();
            bus.mdu_ready = 1'b0;
            bus.mdu_rd = {$urandom, $urandom};
            #1;
            check("resp_valid", bus.out_valid, 1);
            check("resp_data", bus.out_data, exp);
            check("resp_flush", bus.mdu_flush, 0);
            c_valid = 1;
            c_f3 = f;
            c_w = w;
            c_a = a;
            c_b = b;
            c_r = exp;
            last_data = exp;
        end
        check("resp_rd", bus.out_rd_addr, rd);
    endtask

    task automatic hold_resp(input int n);
        for (int k = 0; k < n; k++) begin
            bus.in_valid = 1'($urandom);
            #1;
            check("hold_in_ready", bus.in_ready, 0);
            step();
            #1;
            check("hold_valid", bus.out_valid, 1);
            check("hold_data", bus.out_data, last_data);
            check("hold_mdu_valid", bus.mdu_valid, 0);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic release_idle();
        bus.out_ready = 1'b1;
        #1;
        check("rel_in_ready", bus.in_ready, 1);
        step();
        bus.out_ready = 1'b0;
        #1;
        check("idle_out_valid", bus.out_valid, 0);
        check("idle_in_ready", bus.in_ready, 1);
    endtask

    task automatic do_op(input logic [2:0] f, input logic w, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] rd, input int lat, input logic [63:0] exp, input int stall);
        accept_op(f, w, a, b, rd, 0);
        complete(f, w, a, b, rd, lat, exp);
        hold_resp(stall);
        release_idle();
    endtask

    task automatic flush_now(input bit with_ready);
        bus.pipe_flush = 1'b1;
        bus.mdu_ready = with_ready;
        bus.out_ready = with_ready;
        bus.in_valid = 1'b1;
        #1;
        check("flush_mdu_flush", bus.mdu_flush, 1);
        check("flush_in_ready", bus.in_ready, 0);
        step();
        bus.pipe_flush = 1'b0;
        bus.mdu_ready = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        c_valid = 0;
        #1;
        check("post_flush_out", bus.out_valid, 0);
        check("post_flush_mdu", bus.mdu_valid, 0);
        check("post_flush_ready", bus.in_ready, 1);
        step();
        #1;
        check("post_flush_out2", bus.out_valid, 0);
    endtask

    initial begin
        logic [2:0]  f;
        logic        w;
        logic [63:0] a, b;
        logic [4:0]  rd;
        bit          in_resp;
        bus.pipe_flush = 0;
        bus.in_valid = 0;
        bus.in_funct3 = 0;
        bus.in_word = 0;
        bus.in_rs1 = 0;
        bus.in_rs2 = 0;
        bus.in_rd_addr = 0;
        bus.mdu_ready = 0;
        bus.mdu_rd = 0;
        bus.out_ready = 0;
        @(negedge g_clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_mdu_valid", bus.mdu_valid, 0);
        check("rst_strobes", strb, 0);
        check("rst_mdu_flush", bus.mdu_flush, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_rd", bus.out_rd_addr, 0);
        check("rst_rs1", bus.mdu_rs1, 0);
        @(negedge g_clk);
        g_reset = 1'b0;
        step();

        do_op(3'd0, 0, 64'd7, 64'd6, 5'd5, 3, 64'd42, 2);
        do_op(3'd4, 1, 64'hFFFFFFFFFFFFFFF9, 64'd2, 5'd10, 33, 64'hFFFFFFFFFFFFFFFD, 0);
        do_op(3'd1, 1, 64'd123, 64'd456, 5'd11, 5, 64'd0, 1);

        accept_op(3'd4, 0, 64'd100, 64'd7, 5'd3, 0);
        #1;
        for (int k = 1; k < 10; k++) begin
            check("pre_flush_valid", bus.mdu_valid, 1);
            step();
            #1;
        end
        flush_now(1);
        do_op(3'd0, 0, 64'd3, 64'd5, 5'd4, 2, 64'd15, 0);

        accept_op(3'd0, 0, 64'd3, 64'd5, 5'd6, 0);
        complete(3'd0, 0, 64'd3, 64'd5, 5'd6, 4, 64'd15);
        hold_resp(5);
        accept_op(3'd7, 0, 64'd17, 64'd5, 5'd7, 1);
        complete(3'd7, 0, 64'd17, 64'd5, 5'd7, 4, 64'd2);
        release_idle();

        accept_op(3'd0, 0, 64'd2, 64'd9, 5'd8, 0);
        complete(3'd0, 0, 64'd2, 64'd9, 5'd8, 1, 64'd18);
        flush_now(1);

        a = 64'hDEADBEEF12345678;
        b = 64'h0123456789ABCDEF;
        do_op(3'd3, 0, a, b, 5'd9, 6, mext(3'd3, 0, a, b), 0);
        do_op(3'd3, 0, a, b, 5'd9, 6, mext(3'd3, 0, a, b), 0);
        flush_now(0);
        do_op(3'd3, 0, a, b, 5'd9, 6, mext(3'd3, 0, a, b), 0);

        in_resp = 0;
        for (int i = 0; i < 80; i++) begin
            f = 3'($urandom);
            w = ($urandom % 3) == 0;
            a = rnd64();
            b = rnd64();
            rd = 5'($urandom);
            accept_op(f, w, a, b, rd, in_resp);
            complete(f, w, a, b, rd, $urandom_range(1, 8), mext(f, w, a, b));
            hold_resp($urandom_range(0, 3));
            if ($urandom % 2) in_resp = 1;
            else begin
                release_idle();
                in_resp = 0;
            end
        end
        if (in_resp) release_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
